// File: rtl/ysyx_25020047_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25020047_pkg
//  Description : Shared instruction-class codes, controller state encoding and
//                the default MEM-stage timeout for the execution controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_25020047_pkg;

  // Default number of MEM cycles tolerated before an error halt
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  // One-hot instruction class codes produced by the IDU
  localparam logic [31:0] INST_C00    = 32'h0000_0001;
  localparam logic [31:0] INST_C01    = 32'h0000_0002;
  localparam logic [31:0] INST_C03    = 32'h0000_0008;
  localparam logic [31:0] INST_C04    = 32'h0000_0010;
  localparam logic [31:0] INST_LW     = 32'h0000_0020;
  localparam logic [31:0] INST_LBU    = 32'h0000_0040;
  localparam logic [31:0] INST_SW     = 32'h0000_0080;
  localparam logic [31:0] INST_SB     = 32'h0000_0100;
  localparam logic [31:0] INST_C09    = 32'h0000_0200;
  localparam logic [31:0] INST_C10    = 32'h0000_0400;
  localparam logic [31:0] INST_C11    = 32'h0000_0800;
  localparam logic [31:0] INST_C12    = 32'h0000_1000;
  localparam logic [31:0] INST_C13    = 32'h0000_2000;
  localparam logic [31:0] INST_BEQ    = 32'h0000_4000;
  localparam logic [31:0] INST_BNE    = 32'h0000_8000;
  localparam logic [31:0] INST_C16    = 32'h0001_0000;
  localparam logic [31:0] INST_C17    = 32'h0002_0000;
  localparam logic [31:0] INST_C18    = 32'h0004_0000;
  localparam logic [31:0] INST_EBREAK = 32'h0008_0000;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_25020047_inst_class.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25020047_inst_class
//  Description : Combinational decode of the one-hot instruction class into
//                the control flags the execution controller needs.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25020047_inst_class
  import ysyx_25020047_pkg::*;
(
  input  logic [31:0] inst_type,
  output logic        is_load,
  output logic        is_store,
  output logic        writes_rd,
  output logic        is_ebreak,
  output logic        illegal
);

  // Exact-match decode: zero and multi-hot values fall through to illegal
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    writes_rd = 1'b0;
    is_ebreak = 1'b0;
    illegal   = 1'b0;
    case (inst_type)
      INST_LW, INST_LBU: begin
        is_load   = 1'b1;
        writes_rd = 1'b1;
      end
      INST_SW, INST_SB: begin
        is_store  = 1'b1;
      end
      INST_BEQ, INST_BNE: begin
        // branches only update the PC
      end
      INST_EBREAK: begin
        is_ebreak = 1'b1;
      end
      INST_C00, INST_C01, INST_C03, INST_C04, INST_C09, INST_C10,
      INST_C11, INST_C12, INST_C13, INST_C16, INST_C17, INST_C18: begin
        writes_rd = 1'b1;
      end
      default: begin
        illegal   = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_25020047_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25020047_exec_ctrl
//  Description : Moore multi-cycle execution controller sequencing
//                FETCH / EXEC / MEM / WB with a MEM-stage timeout, a retired
//                instruction counter and a sticky HALT state.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25020047_exec_ctrl
  import ysyx_25020047_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ifu_req,
  input  logic             ifu_ack,
  input  logic [31:0]      inst_type,
  output logic             lsu_req,
  output logic             lsu_wen,
  input  logic             lsu_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  // The counter only has to represent 0 .. MEM_TIMEOUT-1
  localparam int unsigned       TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             err_q, err_d;
  logic             store_q, store_d;
  logic             wrd_q, wrd_d;

  logic w_is_load, w_is_store, w_writes_rd, w_is_ebreak, w_illegal;

  ysyx_25020047_inst_class u_inst_class (
    .inst_type (inst_type),
    .is_load   (w_is_load),
    .is_store  (w_is_store),
    .writes_rd (w_writes_rd),
    .is_ebreak (w_is_ebreak),
    .illegal   (w_illegal)
  );

  // Next-state, counters and Moore outputs
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    retired_d = retired_q;
    err_d     = err_q;
    store_d   = store_q;
    wrd_d     = wrd_q;
    ifu_req   = 1'b0;
    lsu_req   = 1'b0;
    lsu_wen   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    halt      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_ack) state_d = S_EXEC;
      end
      S_EXEC: begin
        // Class flags are frozen here so later inst_type changes are harmless
        store_d  = w_is_store;
        wrd_d    = w_writes_rd;
        to_cnt_d = '0;
        if (w_illegal) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else if (w_is_ebreak) begin
          state_d = S_HALT;
        end else if (w_is_load || w_is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_wen = store_q;
        // An ack in the final allowed cycle still completes the access
        if (lsu_ack) begin
          state_d = S_WB;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_WB: begin
        pc_we     = 1'b1;
        rf_we     = wrd_q;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
      store_q   <= 1'b0;
      wrd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      store_q   <= store_d;
      wrd_q     <= wrd_d;
    end
  end

  assign retired = retired_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_25020047_exec_ctrl
//  Description : Self-checking bench for the execution controller using a
//                per-instruction transaction model of the expected behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020047_exec_ctrl;

  localparam int TMO = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst, start, ifu_ack, lsu_ack;
  logic [31:0]   inst_type;
  logic          ifu_req, lsu_req, lsu_wen, rf_we, pc_we, halt, err;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  logic [31:0] codes [19] = '{32'h1, 32'h2, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80,
                              32'h100, 32'h200, 32'h400, 32'h800, 32'h1000, 32'h2000,
                              32'h4000, 32'h8000, 32'h10000, 32'h20000, 32'h40000,
                              32'h80000};

  ysyx_25020047_exec_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .ifu_req(ifu_req), .ifu_ack(ifu_ack),
    .inst_type(inst_type), .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_ack(lsu_ack),
    .rf_we(rf_we), .pc_we(pc_we), .halt(halt), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Class per instruction: 0 alu-write, 1 branch, 2 load, 3 store, 4 ebreak, 5 illegal
  function automatic int kind_of(input logic [31:0] v);
    bit defined = 1'b0;
    foreach (codes[i]) if (codes[i] == v) defined = 1'b1;
    if (!defined) return 5;
    if (v == 32'h80000) return 4;
    if (v == 32'h20 || v == 32'h40) return 2;
    if (v == 32'h80 || v == 32'h100) return 3;
    if (v == 32'h4000 || v == 32'h8000) return 1;
    return 0;
  endfunction

  // Entered at a negedge with the DUT in FETCH; returns at the next FETCH or in HALT
  task automatic run_instr(input logic [31:0] inst, input int fw, input int lw, input string name);
    int  n_ifu = 0, n_lsu = 0, n_wen = 0, n_pc = 0, n_rf = 0, cyc = 0, k_f = 0, k_m = 0;
    int  e_lsu = 0, e_wen = 0, e_pc = 0, e_rf = 0, e_cyc;
    bit  e_halt = 1'b0, e_err = 1'b0, in_exec = 1'b0, nxt_exec, done = 1'b0;
    int  kind = kind_of(inst);
    e_cyc = fw + 3;
    case (kind)
      0, 1: begin e_pc = 1; e_rf = (kind == 0); end
      2, 3: begin
        if (lw < TMO) begin
          e_lsu = lw + 1; e_cyc += lw + 1; e_pc = 1; e_rf = (kind == 2);
        end else begin
          e_lsu = TMO; e_cyc += TMO; e_halt = 1'b1; e_err = 1'b1;
        end
        e_wen = (kind == 3) ? e_lsu : 0;
      end
      4: e_halt = 1'b1;
      default: begin e_halt = 1'b1; e_err = 1'b1; end
    endcase
    for (int c = 0; c < 200 && !done; c++) begin
      nxt_exec = 1'b0;
      if (ifu_req) begin
        n_ifu++; ifu_ack = (k_f >= fw); nxt_exec = ifu_ack; k_f++;
      end else ifu_ack = 1'($urandom);
      inst_type = in_exec ? inst : $urandom;
      if (lsu_req) begin
        n_lsu++; if (lsu_wen) n_wen++; lsu_ack = (k_m >= lw); k_m++;
      end else lsu_ack = 1'($urandom);
      if (pc_we) n_pc++;
      if (rf_we) n_rf++;
      cyc++;
      if (pc_we || halt) done = 1'b1;
      else begin in_exec = nxt_exec; @(negedge clk); end
    end
    ifu_ack = 1'b0; lsu_ack = 1'b0;
    checks++;
    if (!done || cyc != e_cyc || n_ifu != fw + 1 || n_lsu != e_lsu || n_wen != e_wen ||
        n_pc != e_pc || n_rf != e_rf) begin
      errors++;
      $display("FAIL %s inst=%h shape: got cyc=%0d ifu=%0d lsu=%0d wen=%0d pc=%0d rf=%0d, want cyc=%0d ifu=%0d lsu=%0d wen=%0d pc=%0d rf=%0d",
               name, inst, cyc, n_ifu, n_lsu, n_wen, n_pc, n_rf, e_cyc, fw + 1, e_lsu, e_wen, e_pc, e_rf);
    end
    checks++;
    if (halt !== e_halt || err !== e_err) begin
      errors++;
      $display("FAIL %s halt/err: got %b/%b want %b/%b", name, halt, err, e_halt, e_err);
    end
    if (e_pc == 1) begin
      exp_retired = (exp_retired + 1) % (1 << CW);
      @(negedge clk);
      checks++;
      if (retired !== CW'(exp_retired) || ifu_req !== 1'b1) begin
        errors++;
        $display("FAIL %s retire: got retired=%0d ifu_req=%b want %0d and 1", name, retired, ifu_req, exp_retired);
      end
    end else begin
      checks++;
      if (retired !== CW'(exp_retired)) begin
        errors++;
        $display("FAIL %s retired on halt: got %0d want %0d", name, retired, exp_retired);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ifu_ack = 1'b0; lsu_ack = 1'b0; inst_type = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_retired = 0;
  endtask

  task automatic start_cpu();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ifu_req !== 1'b1) begin
      errors++;
      $display("FAIL start_fetch: ifu_req=%b want 1", ifu_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; ifu_ack = 1'b1; lsu_ack = 1'b1; inst_type = 32'h1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ifu_req, lsu_req, lsu_wen, rf_we, pc_we, halt, err} !== 7'b0 || retired !== '0) begin
      errors++;
      $display("FAIL reset_state: outs=%b retired=%0d want 0000000 and 0",
               {ifu_req, lsu_req, lsu_wen, rf_we, pc_we, halt, err}, retired);
    end
    rst = 1'b0; start = 1'b0; exp_retired = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ifu_req, lsu_req, pc_we, rf_we, halt} !== 5'b0) begin
        errors++;
        $display("FAIL idle_no_start: outs=%b want 00000", {ifu_req, lsu_req, pc_we, rf_we, halt});
      end
    end
  endtask

  task automatic test_basic();
    do_reset(); start_cpu();
    run_instr(32'h1, 0, 0, "alu_first");
  endtask

  task automatic test_mem();
    run_instr(32'h20,   0, 5, "lw_wait5");
    run_instr(32'h80,   1, 2, "sw");
    run_instr(32'h4000, 0, 0, "beq");
    run_instr(32'h100,  0, TMO - 1, "sb_ack_last");
    run_instr(32'h40,   2, 0, "lbu");
    run_instr(32'h8000, 3, 0, "bne");
  endtask

  task automatic check_sticky(input string name, input logic want_err);
    start = 1'b1; ifu_ack = 1'b1; lsu_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (halt !== 1'b1 || err !== want_err || {ifu_req, lsu_req, lsu_wen, rf_we, pc_we} !== 5'b0) begin
        errors++;
        $display("FAIL %s sticky: halt=%b err=%b strobes=%b want 1 %b 00000", name, halt, err,
                 {ifu_req, lsu_req, lsu_wen, rf_we, pc_we}, want_err);
      end
    end
    start = 1'b0; ifu_ack = 1'b0; lsu_ack = 1'b0;
  endtask

  task automatic test_timeout();
    run_instr(32'h20, 0, 1000, "lw_timeout");
    check_sticky("timeout", 1'b1);
  endtask

  task automatic test_halt_codes();
    do_reset(); start_cpu();
    run_instr(32'h3, 0, 0, "multi_hot");
    do_reset(); start_cpu();
    run_instr(32'h0, 1, 0, "zero_code");
    do_reset(); start_cpu();
    run_instr(32'h80000, 0, 0, "ebreak");
    check_sticky("ebreak", 1'b0);
    do_reset();
    @(negedge clk);
    checks++;
    if ({ifu_req, halt, err} !== 3'b0) begin
      errors++;
      $display("FAIL halt_reset: ifu_req/halt/err=%b want 000", {ifu_req, halt, err});
    end
  endtask

  task automatic test_rst_mid_mem();
    bit saw_pc = 1'b0;
    do_reset(); start_cpu();
    run_instr(32'h2, 0, 0, "pre1");
    run_instr(32'h10, 0, 0, "pre2");
    ifu_ack = 1'b1; inst_type = 32'h20;
    @(negedge clk);
    ifu_ack = 1'b0;
    @(negedge clk);
    lsu_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (pc_we) saw_pc = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (lsu_req !== 1'b1 || retired !== CW'(exp_retired)) begin
      errors++;
      $display("FAIL mid_mem: lsu_req=%b retired=%0d want 1 and %0d", lsu_req, retired, exp_retired);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (pc_we) saw_pc = 1'b1;
    checks++;
    if ({ifu_req, lsu_req, pc_we, rf_we, halt} !== 5'b0 || retired !== '0 || saw_pc) begin
      errors++;
      $display("FAIL rst_mid_mem: outs=%b retired=%0d pc_seen=%b want 00000, 0, 0",
               {ifu_req, lsu_req, pc_we, rf_we, halt}, retired, saw_pc);
    end
    exp_retired = 0;
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    do_reset(); start_cpu();
    for (int i = 0; i < 18; i++) begin
      do v = codes[$urandom_range(18, 0)]; while (kind_of(v) > 1);
      run_instr(v, $urandom_range(2, 0), 0, "wrap");
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    do_reset(); start_cpu();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(7, 0))
        0:       v = $urandom;
        1:       v = (32'h1 << $urandom_range(31, 0)) | (32'h1 << $urandom_range(31, 0));
        default: v = codes[$urandom_range(17, 0)];
      endcase
      run_instr(v, $urandom_range(3, 0), $urandom_range(9, 0), "random");
      if (halt) begin do_reset(); start_cpu(); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ifu_ack = 1'b0; lsu_ack = 1'b0; inst_type = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_mem();
    test_timeout();
    test_halt_codes();
    test_rst_mid_mem();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_25020047_exec_ctrl.md
YSYX_25020047_EXEC_CTRL -- requirements
Module: ysyx_25020047_exec_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of MEM-state cycles allowed before an error halt.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the retired-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have ports ifu_req  output  1  fetch request, and ifu_ack  input  1  instruction valid from the IFU.
REQ-007 SHALL have port inst_type  input  32  one-hot instruction class from the IDU, sampled in EXEC.
REQ-008 SHALL have ports lsu_req  output  1, lsu_wen  output  1  (1=store), and lsu_ack  input  1  (memory done).
REQ-009 SHALL have ports rf_we  output  1  regfile write strobe, and pc_we  output  1  PC update strobe (PC <= dnpc).
REQ-010 SHALL have ports halt  output  1, err  output  1, and retired  output  CNT_W  count of completed instructions.

Function
REQ-011 SHALL implement the states IDLE, FETCH, EXEC, MEM, WB and HALT; every output except retired SHALL be a function of the state only (Moore).
REQ-012 IDLE: all strobes SHALL be 0; start=1 SHALL go to FETCH; start SHALL be ignored in every other state.
REQ-013 FETCH: ifu_req SHALL be 1 and held until ifu_ack=1, then go to EXEC; an ack in the first FETCH cycle SHALL be accepted.
REQ-014 EXEC SHALL last one cycle and classify inst_type:
  - lw 0x20, lbu 0x40, sw 0x80, sb 0x100 -> MEM
  - ebreak 0x80000 -> HALT with err=0
  - the other defined codes (0x1, 0x2, 0x8, 0x10, 0x200, 0x400, 0x800, 0x1000, 0x2000, 0x4000, 0x8000, 0x10000, 0x20000, 0x40000) -> WB
  - any other value, including 0 and multi-hot -> HALT with err=1
REQ-015 MEM: lsu_req SHALL be 1; lsu_wen SHALL be 1 only for sw/sb; lsu_ack=1 SHALL go to WB.
REQ-016 MEM SHALL count cycles from 0 on entry; if the count reaches MEM_TIMEOUT without lsu_ack, it SHALL go to HALT with err=1; an ack in that same cycle SHALL win.
REQ-017 WB: pc_we=1 for exactly one cycle; rf_we=1 except for beq 0x4000, bne 0x8000, sw and sb; retired SHALL increment by 1; the next state SHALL be FETCH.
REQ-018 The class captured in EXEC SHALL be registered and used in MEM/WB; inst_type changes after EXEC SHALL have no effect.
REQ-019 ifu_ack outside FETCH and lsu_ack outside MEM SHALL be ignored.
REQ-020 Latency: a non-memory instruction with a same-cycle ack SHALL take 3 cycles (FETCH, EXEC, WB); a memory instruction SHALL take 4 + (lsu wait) cycles.
REQ-021 HALT SHALL be sticky until rst; halt=1 in HALT; err SHALL hold its value; all strobes SHALL be 0.
REQ-022 retired SHALL wrap from 2^CNT_W-1 to 0 without a flag.

Reset
REQ-023 rst=1 SHALL, at the next edge, force IDLE, retired=0, err=0, halt=0, clear the timeout counter and deassert all strobes; this SHALL take priority over every other input.
REQ-024 rst asserted in FETCH or MEM SHALL abort the instruction with no pc_we, rf_we or retired increment.

Structure
REQ-025 Package ysyx_25020047_pkg SHALL hold the inst_type one-hot code constants, the state enum and the MEM_TIMEOUT default; the WBU and the IDU SHALL share the same constants.
REQ-026 A combinational sub-module ysyx_25020047_inst_class SHALL map inst_type to is_load, is_store, writes_rd, is_ebreak and illegal.
REQ-027 The top level SHALL contain the state register, the timeout counter, the retired counter and the registered class flags.

Verification
REQ-028 start; inst_type=0x1; ifu_ack tied 1 -> pc_we and rf_we each pulse once in cycle 3; retired=1; back in FETCH.
REQ-029 lw (0x20); lsu_ack delayed 5 cycles -> lsu_req high 6 cycles with lsu_wen=0; then WB with rf_we=1.
REQ-030 sw (0x80) and beq (0x4000) -> lsu_wen=1 for sw; rf_we=0 in WB for both; pc_we=1 for both.
REQ-031 lw with lsu_ack never asserted, MEM_TIMEOUT=8 -> HALT after 8 MEM cycles, err=1, halt=1, pc_we never asserted.
REQ-032 inst_type=0x3 -> HALT with err=1; inst_type=0x80000 -> HALT with err=0; start afterwards is ignored; rst -> IDLE.
REQ-033 rst pulsed mid-MEM -> IDLE next cycle; retired unchanged from its pre-instruction value, then 0 after reset; no pc_we pulse.
